// File: rtl/sdram_init_seq_if.sv
// SDRAM init sequencer bus.
// master: datapath side; drives cas_sel, reinit_req and sr_req and observes status.
// slave:  the sequencer; drives the status lines and the SDRAM command pins.
// Signals:
//   cas_sel, reinit_req, sr_req           - requests from the datapath
//   reinit_ack, sr_active, bypass, sdram_rst, sdram_initialized, tim_cas - status
//   sdram_cke/cs_n/ras_n/cas_n/we_n/dqm, sdram_adr, sdram_ba          - SDRAM pins
interface sdram_init_seq_if #(
  parameter int unsigned ADR_W = 13,
  parameter int unsigned BA_W  = 2
);
  logic             cas_sel;
  logic             reinit_req;
  logic             reinit_ack;
  logic             sr_req;
  logic             sr_active;
  logic             bypass;
  logic             sdram_rst;
  logic             sdram_initialized;
  logic             tim_cas;
  logic             sdram_cke;
  logic             sdram_cs_n;
  logic             sdram_ras_n;
  logic             sdram_cas_n;
  logic             sdram_we_n;
  logic             sdram_dqm;
  logic [ADR_W-1:0] sdram_adr;
  logic [BA_W-1:0]  sdram_ba;

  modport master (
    output cas_sel, reinit_req, sr_req,
    input  reinit_ack, sr_active, bypass, sdram_rst, sdram_initialized, tim_cas,
    input  sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n, sdram_dqm,
    input  sdram_adr, sdram_ba
  );

  modport slave (
    input  cas_sel, reinit_req, sr_req,
    output reinit_ack, sr_active, bypass, sdram_rst, sdram_initialized, tim_cas,
    output sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n, sdram_dqm,
    output sdram_adr, sdram_ba
  );
endinterface

// File: rtl/sdram_init_seq.sv
// SDRAM power-up / mode sequencer. Owns the SDRAM command pins while bypass=1:
// power-up wait, PRECHARGE ALL, NUM_AREF auto refreshes, LOAD MODE, then hands the
// pins to the datapath. From IDLE it can re-run the init with a new CAS latency or
// enter/leave self-refresh. All outputs are registered.
// Ports:
//   sys_clk, sys_rst_n (async, active low)
//   bus (slave modport): requests in, status and SDRAM pins out.
module sdram_init_seq #(
  parameter int unsigned INIT_CYCLES = 12500,
  parameter int unsigned TRP_CYCLES  = 4,
  parameter int unsigned TRFC_CYCLES = 9,
  parameter int unsigned TMRD_CYCLES = 2,
  parameter int unsigned TXSR_CYCLES = 10,
  parameter int unsigned NUM_AREF    = 2,
  parameter int unsigned ADR_W       = 13,
  parameter int unsigned BA_W        = 2,
  parameter logic [2:0]  BURST_CODE  = 3'b011
) (
  input logic            sys_clk,
  input logic            sys_rst_n,
  sdram_init_seq_if.slave bus
);

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  localparam int unsigned MaxWait = max2(max2(INIT_CYCLES, TRP_CYCLES),
                                         max2(max2(TRFC_CYCLES, TMRD_CYCLES), TXSR_CYCLES));
  localparam int unsigned CntW = $clog2(MaxWait + 1);
  localparam logic [ADR_W-1:0] AdrPall = ADR_W'(1) << 10;

  typedef enum logic [2:0] {
    StPowerup, StPall, StAref, StLmr, StIdle, StSrPall, StSrHold, StSrExit
  } state_e;

  state_e           r_state;
  logic [CntW-1:0]  r_cnt;
  logic [3:0]       r_aref;
  logic             r_reinit;
  logic             r_tim_cas;
  logic             r_cke, r_cs_n, r_ras_n, r_cas_n, r_we_n;
  logic [ADR_W-1:0] r_adr;
  logic [BA_W-1:0]  r_ba;
  logic             r_bypass, r_init, r_sr_active, r_ack;

  logic             w_expired;
  logic [ADR_W-1:0] w_mode_word;

  assign w_expired = (r_cnt == '0);
  // A9=0 (burst writes), A6..A4 = CAS latency, A3=0 (sequential), A2..A0 = burst length.
  assign w_mode_word = ADR_W'({3'b000, 1'b0, r_tim_cas ? 3'b011 : 3'b010, 1'b0, BURST_CODE});

  // Each wait loads N-1 so the next command lands exactly N cycles after the last one.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state     <= StPowerup;
      r_cnt       <= CntW'(INIT_CYCLES);
      r_aref      <= '0;
      r_reinit    <= 1'b0;
      r_tim_cas   <= 1'b0;
      r_cke       <= 1'b0;
      r_cs_n      <= 1'b1;
      r_ras_n     <= 1'b1;
      r_cas_n     <= 1'b1;
      r_we_n      <= 1'b1;
      r_adr       <= '0;
      r_ba        <= '0;
      r_bypass    <= 1'b1;
      r_init      <= 1'b0;
      r_sr_active <= 1'b0;
      r_ack       <= 1'b0;
    end else begin
      // Default every cycle to a NOP with CKE high.
      r_cke   <= 1'b1;
      r_cs_n  <= 1'b0;
      r_ras_n <= 1'b1;
      r_cas_n <= 1'b1;
      r_we_n  <= 1'b1;
      r_adr   <= '0;
      r_ba    <= '0;
      r_ack   <= 1'b0;
      if (!w_expired) r_cnt <= r_cnt - CntW'(1);

      unique case (r_state)
        StPowerup: if (w_expired) begin
          r_tim_cas <= bus.cas_sel;
          r_reinit  <= 1'b0;
          r_ras_n   <= 1'b0;
          r_we_n    <= 1'b0;
          r_adr     <= AdrPall;
          r_aref    <= '0;
          r_cnt     <= CntW'(TRP_CYCLES - 1);
          r_state   <= StPall;
        end
        StPall: if (w_expired) begin
          r_ras_n <= 1'b0;
          r_cas_n <= 1'b0;
          r_aref  <= r_aref + 4'd1;
          r_cnt   <= CntW'(TRFC_CYCLES - 1);
          r_state <= StAref;
        end
        StAref: if (w_expired) begin
          if (r_aref == 4'(NUM_AREF)) begin
            r_ras_n <= 1'b0;
            r_cas_n <= 1'b0;
            r_we_n  <= 1'b0;
            r_adr   <= w_mode_word;
            r_cnt   <= CntW'(TMRD_CYCLES - 1);
            r_state <= StLmr;
          end else begin
            r_ras_n <= 1'b0;
            r_cas_n <= 1'b0;
            r_aref  <= r_aref + 4'd1;
            r_cnt   <= CntW'(TRFC_CYCLES - 1);
          end
        end
        StLmr: if (w_expired) begin
          r_bypass <= 1'b0;
          r_init   <= 1'b1;
          r_ack    <= r_reinit;
          r_state  <= StIdle;
        end
        StIdle: begin
          // Re-init takes priority over self-refresh when both are requested.
          if (bus.reinit_req || bus.sr_req) begin
            r_bypass <= 1'b1;
            r_init   <= 1'b0;
            r_ras_n  <= 1'b0;
            r_we_n   <= 1'b0;
            r_adr    <= AdrPall;
            r_aref   <= '0;
            r_cnt    <= CntW'(TRP_CYCLES - 1);
            if (bus.reinit_req) begin
              r_tim_cas <= bus.cas_sel;
              r_reinit  <= 1'b1;
              r_state   <= StPall;
            end else begin
              r_state   <= StSrPall;
            end
          end
        end
        StSrPall: if (w_expired) begin
          // SELF REFRESH: AUTO REFRESH encoding with CKE dropped in the same cycle.
          r_ras_n     <= 1'b0;
          r_cas_n     <= 1'b0;
          r_cke       <= 1'b0;
          r_sr_active <= 1'b1;
          r_state     <= StSrHold;
        end
        StSrHold: begin
          if (bus.sr_req) begin
            r_cke  <= 1'b0;
            r_cs_n <= 1'b1;
          end else begin
            r_sr_active <= 1'b0;
            r_cnt       <= CntW'(TXSR_CYCLES - 1);
            r_state     <= StSrExit;
          end
        end
        StSrExit: if (w_expired) begin
          r_bypass <= 1'b0;
          r_init   <= 1'b1;
          r_state  <= StIdle;
        end
      endcase
    end
  end

  assign bus.reinit_ack        = r_ack;
  assign bus.sr_active         = r_sr_active;
  assign bus.bypass            = r_bypass;
  assign bus.sdram_rst         = r_bypass;
  assign bus.sdram_initialized = r_init;
  assign bus.tim_cas           = r_tim_cas;
  assign bus.sdram_cke         = r_cke;
  assign bus.sdram_cs_n        = r_cs_n;
  assign bus.sdram_ras_n       = r_ras_n;
  assign bus.sdram_cas_n       = r_cas_n;
  assign bus.sdram_we_n        = r_we_n;
  // The sequencer never moves data, so DQM stays high.
  assign bus.sdram_dqm         = 1'b1;
  assign bus.sdram_adr         = r_adr;
  assign bus.sdram_ba          = r_ba;

endmodule

// File: tb/tb_sdram_init_seq.sv
module tb_sdram_init_seq;
  localparam int unsigned INIT = 20, TRP = 3, TRFC = 5, TMRD = 2, TXSR = 6, NAREF = 3;
  localparam int unsigned AW = 13, BW = 2;
  localparam int BIG = 1000000000;
  // {cs_n, ras_n, cas_n, we_n}
  localparam logic [3:0] P_NOP = 4'b0111, P_PALL = 4'b0010, P_AREF = 4'b0001;
  localparam logic [3:0] P_LMR = 4'b0000, P_DESEL = 4'b1111;

  logic sys_clk = 1'b0;
  logic sys_rst_n = 1'b0;

  sdram_init_seq_if #(.ADR_W(AW), .BA_W(BW)) bus ();

  sdram_init_seq #(
    .INIT_CYCLES(INIT), .TRP_CYCLES(TRP), .TRFC_CYCLES(TRFC), .TMRD_CYCLES(TMRD),
    .TXSR_CYCLES(TXSR), .NUM_AREF(NAREF), .ADR_W(AW), .BA_W(BW), .BURST_CODE(3'b011)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .bus      (bus.slave)
  );

  always #5 sys_clk = ~sys_clk;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // ---------------- reference model: a timeline of planned events ----------------
  logic [3:0]    exp_pins[int];
  logic [AW-1:0] exp_adr[int];
  int  seq_end = BIG;   // cycle at which IDLE becomes visible
  int  ack_at = -1;
  int  sr_cmd_t = BIG;  // SELF REFRESH command cycle
  int  sr_exit_t = BIG; // cycle CKE returns high
  bit  sr_wait = 1'b0;
  bit  m_cl = 1'b0;

  // command log taken from the DUT pins, plus audit state
  typedef struct { int t; logic [3:0] pv; logic [AW-1:0] adr; logic cke; } ev_t;
  ev_t log_q[$];
  int  last_t = -1;
  int  last_need = 0;
  int  ack_count = 0;

  function automatic logic [AW-1:0] lmr_word(input bit cl);
    return AW'(10'h020 | (cl ? 10'h010 : 10'h000) | 10'h003);
  endfunction

  task automatic model_reset();
    cyc = 0; seq_end = BIG; ack_at = -1; sr_cmd_t = BIG; sr_exit_t = BIG;
    sr_wait = 1'b0; m_cl = 1'b0; last_t = -1;
    exp_pins.delete(); exp_adr.delete();
  endtask

  task automatic plan_init(input int t0, input bit re);
    int l;
    exp_pins[t0] = P_PALL; exp_adr[t0] = AW'(13'h400);
    for (int i = 0; i < int'(NAREF); i++) begin
      exp_pins[t0 + TRP + i * TRFC] = P_AREF; exp_adr[t0 + TRP + i * TRFC] = '0;
    end
    l = t0 + TRP + NAREF * TRFC;
    exp_pins[l] = P_LMR; exp_adr[l] = lmr_word(m_cl);
    seq_end = l + TMRD;
    ack_at = re ? seq_end : -1;
  endtask

  task automatic model_step(input int c);
    if (c == int'(INIT) + 1) begin
      m_cl = bus.cas_sel; plan_init(c, 1'b0);
    end else if (sr_wait && c > sr_cmd_t && !bus.sr_req) begin
      sr_wait = 1'b0; sr_exit_t = c; seq_end = c + TXSR;
    end else if (c > seq_end) begin
      if (bus.reinit_req) begin
        m_cl = bus.cas_sel; plan_init(c, 1'b1);
      end else if (bus.sr_req) begin
        exp_pins[c] = P_PALL; exp_adr[c] = AW'(13'h400);
        exp_pins[c + TRP] = P_AREF; exp_adr[c + TRP] = '0;
        sr_cmd_t = c + TRP; sr_exit_t = BIG; sr_wait = 1'b1; seq_end = BIG;
      end
    end
  endtask

  task automatic compare_cycle(input int c);
    logic [3:0] ep, pv;
    logic [AW-1:0] ea;
    bit low, idle;
    low  = (c >= sr_cmd_t) && (c < sr_exit_t);
    idle = (c >= seq_end);
    if (exp_pins.exists(c)) begin ep = exp_pins[c]; ea = exp_adr[c]; end
    else if (c > sr_cmd_t && c < sr_exit_t) begin ep = P_DESEL; ea = '0; end
    else begin ep = P_NOP; ea = '0; end
    check("pins", {bus.sdram_cke, bus.sdram_cs_n, bus.sdram_ras_n, bus.sdram_cas_n,
                   bus.sdram_we_n, bus.sdram_dqm, bus.sdram_ba, bus.sdram_adr},
                  {!low, ep, 1'b1, 2'b00, ea});
    check("status", {bus.bypass, bus.sdram_rst, bus.sdram_initialized, bus.sr_active,
                     bus.reinit_ack, bus.tim_cas},
                    {!idle, !idle, idle, low, (c == ack_at), m_cl});
    if (bus.reinit_ack === 1'b1) ack_count++;
    // timing audit on whatever commands actually appear on the pins
    pv = {bus.sdram_cs_n, bus.sdram_ras_n, bus.sdram_cas_n, bus.sdram_we_n};
    if (pv != P_NOP && pv != P_DESEL) begin
      if (last_t >= 0) check("cmd_gap_ok", 64'(c - last_t >= last_need), 64'd1);
      last_t = c;
      if (pv == P_PALL) last_need = TRP;
      else if (pv == P_AREF) last_need = bus.sdram_cke ? TRFC : TXSR;
      else last_need = TMRD;
      log_q.push_back('{t: c, pv: pv, adr: bus.sdram_adr, cke: bus.sdram_cke});
    end
  endtask

  always @(posedge sys_clk) begin
    if (!sys_rst_n) model_reset();
    else begin
      cyc++;
      model_step(cyc);
      #1;
      compare_cycle(cyc);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic check_reset_vals(input string name);
    check(name, {bus.sdram_cke, bus.sdram_cs_n, bus.sdram_ras_n, bus.sdram_cas_n,
                 bus.sdram_we_n, bus.sdram_dqm, bus.sdram_ba, bus.sdram_adr, bus.bypass,
                 bus.sdram_rst, bus.sdram_initialized, bus.sr_active, bus.reinit_ack,
                 bus.tim_cas},
                {1'b0, 4'b1111, 1'b1, 2'b00, 13'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
  endtask

  task automatic wait_idle(input string name, input int bound);
    int k = 0;
    while (bus.sdram_initialized !== 1'b1 && k < bound) begin @(negedge sys_clk); k++; end
    check(name, bus.sdram_initialized, 1);
  endtask

  task automatic wait_sr(input string name, input int bound);
    int k = 0;
    while (bus.sr_active !== 1'b1 && k < bound) begin @(negedge sys_clk); k++; end
    check(name, bus.sr_active, 1);
  endtask

  // reinit_req must already be high; drops it on the ack cycle
  task automatic wait_ack(input string name, input int bound);
    int k = 0;
    do begin @(negedge sys_clk); k++; end while (bus.reinit_ack !== 1'b1 && k < bound);
    check(name, bus.reinit_ack, 1);
    bus.reinit_req = 1'b0;
  endtask

  task automatic do_sr(input int hold);
    bus.sr_req = 1'b1;
    wait_sr("sr_entered", 60);
    repeat (hold) @(negedge sys_clk);
    bus.sr_req = 1'b0;
    wait_idle("sr_exit_idle", 60);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, acks0, op;
    logic [3:0] lit_p[5];
    int lit_t[5];
    lit_t = '{21, 24, 29, 34, 39};
    lit_p = '{P_PALL, P_AREF, P_AREF, P_AREF, P_LMR};
    bus.cas_sel = 1'b0; bus.reinit_req = 1'b0; bus.sr_req = 1'b0;

    // power-up, CL2
    repeat (3) @(negedge sys_clk);
    check_reset_vals("reset_values");
    sys_rst_n = 1'b1;
    repeat (40) @(negedge sys_clk);
    check("init_low_c40", bus.sdram_initialized, 0);
    @(negedge sys_clk);
    check("init_high_c41", {bus.sdram_initialized, bus.bypass}, 2'b10);
    check("powerup_cmd_count", log_q.size(), 5);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("powerup_cmd%0d_time", i), log_q[i].t, lit_t[i]);
      check($sformatf("powerup_cmd%0d_kind", i), log_q[i].pv, lit_p[i]);
    end
    check("powerup_pall_a10", log_q[0].adr, 13'h400);
    check("powerup_lmr_adr", log_q[4].adr, 13'h023);

    // reset from IDLE, then reset again during the second AREF
    sys_rst_n = 1'b0; #1;
    check_reset_vals("reset_from_idle");
    repeat (2) @(negedge sys_clk);
    bus.cas_sel = 1'b1; sys_rst_n = 1'b1;
    base = log_q.size();
    repeat (29) @(negedge sys_clk);
    check("second_aref_time", log_q[log_q.size() - 1].t, 29);
    check("second_aref_kind", log_q[log_q.size() - 1].pv, P_AREF);
    check("second_aref_cl3_latched", bus.tim_cas, 1);
    sys_rst_n = 1'b0; #1;
    check_reset_vals("reset_mid_sequence");
    repeat (2) @(negedge sys_clk);
    bus.cas_sel = 1'($urandom_range(0, 1)); sys_rst_n = 1'b1;
    wait_idle("restart_idle", 100);

    // directed re-init to CL3
    @(negedge sys_clk);
    acks0 = ack_count; base = log_q.size();
    bus.cas_sel = 1'b1; bus.reinit_req = 1'b1;
    @(negedge sys_clk);
    check("reinit_bypass_next", {bus.bypass, bus.sdram_initialized}, 2'b10);
    wait_ack("reinit_ack", 100);
    check("reinit_cmds", log_q.size() - base, 5);
    check("reinit_lmr_adr", log_q[base + 4].adr, 13'h033);
    check("reinit_tim_cas", bus.tim_cas, 1);
    @(negedge sys_clk);
    check("reinit_one_ack", ack_count - acks0, 1);
    check("reinit_bypass_off", bus.bypass, 0);

    // directed self-refresh, 20 cycles
    acks0 = ack_count; base = log_q.size();
    bus.sr_req = 1'b1;
    repeat (20) @(negedge sys_clk);
    bus.sr_req = 1'b0;
    wait_idle("sr20_idle", 60);
    check("sr20_pall", log_q[base].pv, P_PALL);
    check("sr20_sref", {log_q[base + 1].pv, log_q[base + 1].cke}, {P_AREF, 1'b0});
    check("sr20_no_ack", ack_count - acks0, 0);

    // simultaneous requests; then reinit during SR hold
    @(negedge sys_clk);
    bus.cas_sel = 1'b0; bus.reinit_req = 1'b1; bus.sr_req = 1'b1;
    wait_ack("both_reinit_first", 100);
    wait_sr("both_then_sr", 60);
    repeat (3) @(negedge sys_clk);
    bus.cas_sel = 1'b1; bus.reinit_req = 1'b1;
    repeat (4) @(negedge sys_clk);
    check("hold_ignores_reinit", {bus.sr_active, bus.sdram_cke}, 2'b10);
    bus.sr_req = 1'b0;
    wait_ack("reinit_after_sr", 100);
    check("reinit_after_sr_cas", bus.tim_cas, 1);

    // randomized mix
    for (int it = 0; it < 12; it++) begin
      op = $urandom_range(0, 3);
      @(negedge sys_clk);
      unique case (op)
        0: begin
          bus.cas_sel = 1'($urandom_range(0, 1)); bus.reinit_req = 1'b1;
          wait_ack("rand_reinit", 100);
        end
        1: do_sr($urandom_range(0, 15));
        2: begin
          bus.cas_sel = 1'($urandom_range(0, 1));
          bus.reinit_req = 1'b1; bus.sr_req = 1'b1;
          wait_ack("rand_both", 100);
          wait_sr("rand_both_sr", 60);
          repeat ($urandom_range(0, 8)) @(negedge sys_clk);
          bus.sr_req = 1'b0;
          wait_idle("rand_both_idle", 60);
        end
        default: begin
          repeat ($urandom_range(1, 10)) begin
            bus.cas_sel = 1'($urandom_range(0, 1));
            @(negedge sys_clk);
          end
        end
      endcase
    end

    repeat (3) @(negedge sys_clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/sdram_init_seq.md
Name: sdram_init_seq

Overview:
- Parametrised SDRAM power-up and mode sequencer. Drives the SDRAM command pins while the HPDMC datapath is bypassed, then hands the pins over via `bypass`.
- Extends the fixed-count init block in four ways:
  - configurable timing and auto-refresh count;
  - runtime CAS-latency selection with re-initialisation (PRECHARGE ALL, refreshes, LOAD MODE) on request;
  - self-refresh entry and exit;
  - fully registered command outputs.
- Sits between the system clock/reset domain and the SDRAM pin mux, beside the HPDMC control path.

Parameters:
- INIT_CYCLES, 12500, power-up wait (100 us at 125 MHz) before first PRECHARGE ALL
- TRP_CYCLES, 4, clocks from PRECHARGE ALL to next command
- TRFC_CYCLES, 9, clocks from AUTO REFRESH to next command
- TMRD_CYCLES, 2, clocks from LOAD MODE to IDLE
- TXSR_CYCLES, 10, clocks from self-refresh exit (CKE high) to IDLE
- NUM_AREF, 2, auto-refresh commands per init (1..15)
- ADR_W, 13, SDRAM address width (>=11)
- BA_W, 2, bank address width
- BURST_CODE, 3'b011, mode register A2..A0 (burst length 8)

Ports:
- sys_clk  in  1  system clock
- sys_rst_n  in  1  asynchronous active-low reset
- cas_sel  in  1  CAS latency for next LOAD MODE: 0 = CL2, 1 = CL3
- reinit_req  in  1  request full re-init; held until reinit_ack
- reinit_ack  out  1  one-cycle pulse on return to IDLE after a re-init
- sr_req  in  1  level; 1 = enter/stay in self-refresh, 0 = exit
- sr_active  out  1  1 while CKE is held low in self-refresh
- bypass  out  1  1 = this block owns the SDRAM pins
- sdram_rst  out  1  1 holds the HPDMC datapath in reset
- sdram_initialized  out  1  1 when in IDLE with a valid mode
- tim_cas  out  1  current CAS latency (0 = CL2), to the datapath
- sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n, sdram_dqm  out  1 each  SDRAM command pins
- sdram_adr  out  ADR_W  SDRAM address
- sdram_ba  out  BA_W  SDRAM bank

Behaviour:
- Reset (sys_rst_n low, asynchronous) puts every output at its reset value immediately:
  - cke=0, cs_n/ras_n/cas_n/we_n=1, dqm=1, adr=0, ba=0;
  - bypass=1, sdram_rst=1, sdram_initialized=0, sr_active=0, reinit_ack=0;
  - tim_cas=cas_sel is not sampled; tim_cas=0.
  - A reset asserted mid-sequence restarts from POWERUP on release.
- Command outputs are registered: a command decided in state S on cycle T appears on the pins at cycle T+1 for exactly one cycle. Every non-command cycle drives NOP (cs_n=0, ras_n/cas_n/we_n=1).
- A single down-counter sized for max(INIT_CYCLES, TRP, TRFC, TMRD, TXSR) times every wait. A wait of N means the next command appears exactly N cycles after the previous one.
- State machine:
  - POWERUP: cke=1 from the first cycle after reset. Wait INIT_CYCLES, then go to PALL.
  - PALL: issue PRECHARGE ALL (ras_n=0, we_n=0, adr[10]=1). Wait TRP.
  - AREF: issue AUTO REFRESH (ras_n=0, cas_n=0). Wait TRFC. Repeat until NUM_AREF have been issued (refresh counter reset on PALL entry).
  - LMR: issue LOAD MODE (ras/cas/we_n=0, ba=0). adr = zeros above A9, A9=0, A6..A4 = 3'b010 or 3'b011 from the latched CL, A3=0, A2..A0 = BURST_CODE. Wait TMRD, then go to IDLE.
  - IDLE: bypass=0, sdram_rst=0, sdram_initialized=1.
- cas_sel is latched into tim_cas at POWERUP exit and on reinit accept. It is not sampled at any other time.
- Exits from IDLE (evaluated each cycle):
  - reinit_req=1: latch cas_sel, set bypass=1 and sdram_initialized=0 on the next cycle, run PALL, AREF xNUM_AREF, LMR, then return to IDLE and pulse reinit_ack.
  - sr_req=1 and reinit_req=0: go to SR_PALL. reinit_req wins if both are high.
- Self-refresh sequence:
  - SR_PALL: PRECHARGE ALL, wait TRP.
  - SR_ENTER: SELF REFRESH command (as AUTO REFRESH with cke=0 in the same cycle).
  - SR_HOLD: cke=0, cs_n=1, sr_active=1; reinit_req is ignored. When sr_req=0, set cke=1 (NOPs) and go to SR_EXIT.
  - SR_EXIT: wait TXSR, then return to IDLE. No reinit_ack.
- reinit_req or sr_req asserted outside IDLE has no effect until IDLE is reached. A request still held at that point is then serviced.
- The datapath must be quiescent when it raises reinit_req or sr_req. This block does not arbitrate with in-flight bursts.

Test Plan:
- All tests override parameters to INIT=20, TRP=3, TRFC=5, TMRD=2, TXSR=6, NUM_AREF=3.
- Power-up with cas_sel=0: release reset at cycle 0. Required: PALL on the pins at cycle 21, AREFs at 24, 29 and 34, LMR at 39 with adr=0x023. IDLE and sdram_initialized=1 by cycle 41.
- Reset mid-sequence: assert sys_rst_n=0 during the second AREF. Required: all outputs at reset values within the same cycle (asynchronous), and a full sequence restarts after release.
- Re-init: in IDLE set cas_sel=1 and reinit_req=1. Required: bypass=1 on the next cycle, 1 PALL, 3 AREF, LMR adr=0x033, tim_cas=1, a single reinit_ack pulse, bypass=0.
- Self-refresh: hold sr_req=1 for 20 cycles from IDLE. Required: PALL, then SELF REFRESH with cke=0, sr_active=1 throughout the hold. After release: cke=1, NOPs for 6 cycles, IDLE, no reinit_ack.
- Simultaneous requests: raise reinit_req and sr_req together in IDLE. Required: re-init runs first, then the self-refresh sequence starts from IDLE. reinit_req raised during SR_HOLD is ignored until exit.
- Timing audit: a monitor checks that no command is followed by another within less than TRP, TRFC or TMRD cycles, across all tests.
